// File: rtl/adc_pair_filter_if.sv
// Sample-pair input bus and averaged-result output bus of the ADC pair filter.
interface adc_pair_filter_if;
    logic        sample_valid;
    logic [11:0] in_a;
    logic [11:0] in_b;
    logic        clear;
    logic        avg_valid;
    logic [11:0] avg_a;
    logic [11:0] avg_b;
    logic [12:0] diff;
    logic        fault;

    // Upstream side: XADC sampling stage / coil control.
    modport master (
        output sample_valid, in_a, in_b, clear,
        input  avg_valid, avg_a, avg_b, diff, fault
    );

    // Filter side.
    modport slave (
        input  sample_valid, in_a, in_b, clear,
        output avg_valid, avg_a, avg_b, diff, fault
    );
endinterface

// File: rtl/adc_pair_filter.sv
// Box-car average of 2**LOG2_N channel A/B sample pairs with signed A-B output
// and a sticky over-range fault. Samples are taken on the rising edge of
// sample_valid so a held level counts once.
module adc_pair_filter #(
    parameter int unsigned LOG2_N       = 4,
    parameter logic [11:0] FAULT_THRESH = 12'd3900,
    parameter int unsigned FAULT_COUNT  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    adc_pair_filter_if.slave bus
);
    localparam int unsigned AW   = 12 + LOG2_N;
    localparam logic [3:0]  W_FC = 4'(FAULT_COUNT);

    typedef enum logic {
        ACC,
        OUT
    } state_t;

    state_t            r_state;
    logic              r_sv_d;
    logic [AW-1:0]     r_acc_a;
    logic [AW-1:0]     r_acc_b;
    logic [LOG2_N-1:0] r_cnt;
    logic [3:0]        r_over_cnt;
    logic              r_avg_valid;
    logic [11:0]       r_avg_a;
    logic [11:0]       r_avg_b;
    logic [12:0]       r_diff;
    logic              r_fault;

    logic              w_accept;
    logic              w_over;
    logic [AW-1:0]     w_in_a;
    logic [AW-1:0]     w_in_b;
    logic [11:0]       w_avg_a;
    logic [11:0]       w_avg_b;

    assign w_accept = bus.sample_valid & ~r_sv_d;
    assign w_over   = (bus.in_a >= FAULT_THRESH) || (bus.in_b >= FAULT_THRESH);
    assign w_in_a   = {{LOG2_N{1'b0}}, bus.in_a};
    assign w_in_b   = {{LOG2_N{1'b0}}, bus.in_b};
    assign w_avg_a  = r_acc_a[AW-1 -: 12];
    assign w_avg_b  = r_acc_b[AW-1 -: 12];

    assign bus.avg_valid = r_avg_valid;
    assign bus.avg_a     = r_avg_a;
    assign bus.avg_b     = r_avg_b;
    assign bus.diff      = r_diff;
    assign bus.fault     = r_fault;

    // Edge detect, accumulate/publish FSM and over-range fault tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ACC;
            r_sv_d      <= 1'b1;
            r_acc_a     <= '0;
            r_acc_b     <= '0;
            r_cnt       <= '0;
            r_over_cnt  <= '0;
            r_avg_valid <= 1'b0;
            r_avg_a     <= '0;
            r_avg_b     <= '0;
            r_diff      <= '0;
            r_fault     <= 1'b0;
        end else begin
            r_sv_d      <= bus.sample_valid;
            r_avg_valid <= 1'b0;
            if (bus.clear) begin
                r_state    <= ACC;
                r_acc_a    <= '0;
                r_acc_b    <= '0;
                r_cnt      <= '0;
                r_over_cnt <= '0;
                r_fault    <= 1'b0;
            end else begin
                // Fault lags the run counter by one cycle.
                if (r_over_cnt == W_FC) begin
                    r_fault <= 1'b1;
                end
                if (w_accept) begin
                    if (w_over) begin
                        if (r_over_cnt != W_FC) begin
                            r_over_cnt <= r_over_cnt + 4'd1;
                        end
                    end else begin
                        r_over_cnt <= '0;
                    end
                end
                case (r_state)
                    ACC: begin
                        if (w_accept) begin
                            r_acc_a <= r_acc_a + w_in_a;
                            r_acc_b <= r_acc_b + w_in_b;
                            r_cnt   <= r_cnt + LOG2_N'(1);
                            if (&r_cnt) begin
                                r_state <= OUT;
                            end
                        end
                    end
                    OUT: begin
                        r_avg_valid <= 1'b1;
                        r_avg_a     <= w_avg_a;
                        r_avg_b     <= w_avg_b;
                        r_diff      <= {1'b0, w_avg_a} - {1'b0, w_avg_b};
                        r_state     <= ACC;
                        // A sample arriving here starts the next window.
                        if (w_accept) begin
                            r_acc_a <= w_in_a;
                            r_acc_b <= w_in_b;
                            r_cnt   <= LOG2_N'(1);
                        end else begin
                            r_acc_a <= '0;
                            r_acc_b <= '0;
                            r_cnt   <= '0;
                        end
                    end
                    default: r_state <= ACC;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_adc_pair_filter.sv
// Randomised and directed bench for adc_pair_filter (N = 4 pairs per average).
module tb_adc_pair_filter;
    localparam int unsigned N  = 4;
    localparam int unsigned TH = 3900;
    localparam int          FC = 3;

    logic clk;
    logic rst_n;
    adc_pair_filter_if bus_if ();

    adc_pair_filter #(
        .LOG2_N      (2),
        .FAULT_THRESH(12'd3900),
        .FAULT_COUNT (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Reference: list of accepted pairs reduced to window sums and a run length.
    bit          m_prev  = 1'b1;
    bit          m_acc   = 1'b0;
    int unsigned m_sa    = 0;
    int unsigned m_sb    = 0;
    int unsigned m_n     = 0;
    int          m_run   = 0;
    bit          m_pend  = 1'b0;
    int unsigned m_pa    = 0;
    int unsigned m_pb    = 0;
    logic        m_valid = 1'b0;
    logic [11:0] m_a     = '0;
    logic [11:0] m_b     = '0;
    logic [12:0] m_diff  = '0;
    logic        m_fault = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Model: a window completed at one edge is published at the next edge.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_prev = 1'b1; m_sa = 0; m_sb = 0; m_n = 0; m_run = 0; m_pend = 1'b0;
                m_valid = 1'b0; m_a = '0; m_b = '0; m_diff = '0; m_fault = 1'b0;
            end else begin
                m_acc  = bus_if.sample_valid && !m_prev;
                m_prev = bus_if.sample_valid;
                if (bus_if.clear) begin
                    m_sa = 0; m_sb = 0; m_n = 0; m_run = 0; m_pend = 1'b0;
                    m_valid = 1'b0; m_fault = 1'b0;
                end else begin
                    m_valid = m_pend;
                    if (m_pend) begin
                        m_a    = 12'(m_pa);
                        m_b    = 12'(m_pb);
                        m_diff = 13'(int'(m_pa) - int'(m_pb));
                        m_pend = 1'b0;
                    end
                    if (m_run >= FC) m_fault = 1'b1;
                    if (m_acc) begin
                        m_sa += bus_if.in_a;
                        m_sb += bus_if.in_b;
                        m_n++;
                        if (bus_if.in_a >= TH || bus_if.in_b >= TH) m_run++;
                        else m_run = 0;
                        if (m_n == N) begin
                            m_pend = 1'b1;
                            m_pa = m_sa / N;
                            m_pb = m_sb / N;
                            m_sa = 0; m_sb = 0; m_n = 0;
                        end
                    end
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("avg_valid", 16'(bus_if.avg_valid), 16'(m_valid));
                check("avg_a", 16'(bus_if.avg_a), 16'(m_a));
                check("avg_b", 16'(bus_if.avg_b), 16'(m_b));
                check("diff", 16'(bus_if.diff), 16'(m_diff));
                check("fault", 16'(bus_if.fault), 16'(m_fault));
            end
        end
    end

    task automatic pulse(input logic [11:0] a, input logic [11:0] b);
        bus_if.sample_valid = 1'b1;
        bus_if.in_a = a;
        bus_if.in_b = b;
        @(negedge clk);
        bus_if.sample_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_clear();
        bus_if.clear = 1'b1;
        @(negedge clk);
        bus_if.clear = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        bus_if.sample_valid = 1'b0;
        bus_if.in_a = '0;
        bus_if.in_b = '0;
        bus_if.clear = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_avg_a", 16'(bus_if.avg_a), 16'd0);
        check("reset_fault", 16'(bus_if.fault), 16'd0);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // Plain average; strobe two edges after the 4th accept, then holds.
        pulse(12'd100, 12'd50); pulse(12'd200, 12'd50);
        pulse(12'd300, 12'd50); pulse(12'd400, 12'd50);
        check("t1_valid", 16'(bus_if.avg_valid), 16'd1);
        check("t1_avg_a", 16'(bus_if.avg_a), 16'd250);
        check("t1_avg_b", 16'(bus_if.avg_b), 16'd50);
        check("t1_diff", 16'(bus_if.diff), 16'd200);
        @(negedge clk);
        check("t1_strobe_len", 16'(bus_if.avg_valid), 16'd0);
        check("t1_hold", 16'(bus_if.avg_a), 16'd250);

        // Most negative difference.
        repeat (4) pulse(12'd0, 12'd4095);
        check("t2_avg_b", 16'(bus_if.avg_b), 16'd4095);
        check("t2_diff", 16'(bus_if.diff), 16'h1001);

        // Level held high counts once.
        bus_if.sample_valid = 1'b1; bus_if.in_a = 12'd10; bus_if.in_b = 12'd0;
        repeat (20) @(negedge clk);
        bus_if.sample_valid = 1'b0;
        @(negedge clk);
        pulse(12'd30, 12'd0); pulse(12'd30, 12'd0);
        check("t3_no_early", 16'(bus_if.avg_valid), 16'd0);
        pulse(12'd30, 12'd0);
        check("t3_valid", 16'(bus_if.avg_valid), 16'd1);
        check("t3_avg_a", 16'(bus_if.avg_a), 16'd25);

        // Fault needs three consecutive over-range pairs and is sticky.
        do_clear();
        pulse(12'd3950, 12'd0); pulse(12'd3950, 12'd0); pulse(12'd100, 12'd0);
        pulse(12'd3950, 12'd0); pulse(12'd3950, 12'd0);
        check("t4_fault_low", 16'(bus_if.fault), 16'd0);
        pulse(12'd3950, 12'd0);
        check("t4_fault_set", 16'(bus_if.fault), 16'd1);
        pulse(12'd100, 12'd0); pulse(12'd100, 12'd0);
        check("t4_fault_sticky", 16'(bus_if.fault), 16'd1);
        do_clear();
        check("t4_fault_clear", 16'(bus_if.fault), 16'd0);

        // Clear drops the partial window and a coincident sample.
        repeat (3) pulse(12'd500, 12'd0);
        bus_if.sample_valid = 1'b1; bus_if.in_a = 12'd2000; bus_if.clear = 1'b1;
        @(negedge clk);
        bus_if.sample_valid = 1'b0; bus_if.clear = 1'b0;
        @(negedge clk);
        repeat (3) pulse(12'd1000, 12'd0);
        check("t5_no_early", 16'(bus_if.avg_valid), 16'd0);
        pulse(12'd1000, 12'd0);
        check("t5_valid", 16'(bus_if.avg_valid), 16'd1);
        check("t5_avg_a", 16'(bus_if.avg_a), 16'd1000);

        // Async reset mid-window with sample_valid high.
        repeat (3) pulse(12'd3950, 12'd0);
        check("t6_fault_pre", 16'(bus_if.fault), 16'd1);
        bus_if.sample_valid = 1'b1; bus_if.in_a = 12'd5;
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_avg_a", 16'(bus_if.avg_a), 16'd0);
        check("t6_rst_diff", 16'(bus_if.diff), 16'd0);
        check("t6_rst_fault", 16'(bus_if.fault), 16'd0);
        check("t6_rst_valid", 16'(bus_if.avg_valid), 16'd0);
        @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        bus_if.sample_valid = 1'b0;
        @(negedge clk);
        repeat (3) pulse(12'd200, 12'd0);
        check("t6_no_early", 16'(bus_if.avg_valid), 16'd0);
        pulse(12'd200, 12'd0);
        check("t6_valid", 16'(bus_if.avg_valid), 16'd1);
        check("t6_avg_a", 16'(bus_if.avg_a), 16'd200);

        // Random traffic: levels, pulses, near-threshold values, clears, resets.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            bus_if.sample_valid = ($urandom_range(1, 0) == 1);
            bus_if.in_a = ($urandom_range(2, 0) == 0) ? 12'($urandom_range(4095, 3850))
                                                      : 12'($urandom_range(4095, 0));
            bus_if.in_b = ($urandom_range(2, 0) == 0) ? 12'($urandom_range(4095, 3850))
                                                      : 12'($urandom_range(4095, 0));
            bus_if.clear = ($urandom_range(127, 0) == 0);
            if ($urandom_range(999, 0) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        bus_if.sample_valid = 1'b0;
        bus_if.clear = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
